// File: rtl/debounce_pkg.sv
// Shared types and defaults for the contact debouncer.
package debounce_pkg;

    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_STABLE_LOW   = 2'd0,
        ST_PENDING_HIGH = 2'd1,
        ST_STABLE_HIGH  = 2'd2,
        ST_PENDING_LOW  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain that brings an asynchronous level into the aclk domain.
module sync_chain
    import debounce_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic aclk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce.sv
// Debouncer: out follows the synchronized input only after it has held a new
// level for CYCLES consecutive clocks; any glitch restarts qualification.
module debounce
    import debounce_pkg::*;
#(
    parameter int CYCLES      = 1000,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic aclk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int             CW   = $clog2(CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    if (CYCLES < 2 || CYCLES > 65535) begin : g_bad_cycles
        $error("debounce: CYCLES out of range 2..65535");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("debounce: SYNC_STAGES out of range 2..4");
    end

    logic          w_s;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_out, w_out_nxt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .aclk  (aclk),
        .reset (reset),
        .d     (in),
        .q     (w_s)
    );

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state <= ST_STABLE_LOW;
            r_count <= '0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // Count holds the number of consecutive samples that disagreed with out;
    // reaching CYCLES-1 before the next disagreeing sample commits the toggle.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_out_nxt   = r_out;
        case (r_state)
            ST_STABLE_LOW: begin
                if (w_s) begin
                    w_state_nxt = ST_PENDING_HIGH;
                    w_count_nxt = ONE;
                end
            end
            ST_PENDING_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = ST_STABLE_LOW;
                    w_count_nxt = '0;
                end else if (r_count == LAST) begin
                    w_state_nxt = ST_STABLE_HIGH;
                    w_count_nxt = '0;
                    w_out_nxt   = 1'b1;
                end else begin
                    w_count_nxt = r_count + ONE;
                end
            end
            ST_STABLE_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = ST_PENDING_LOW;
                    w_count_nxt = ONE;
                end
            end
            ST_PENDING_LOW: begin
                if (w_s) begin
                    w_state_nxt = ST_STABLE_HIGH;
                    w_count_nxt = '0;
                end else if (r_count == LAST) begin
                    w_state_nxt = ST_STABLE_LOW;
                    w_count_nxt = '0;
                    w_out_nxt   = 1'b0;
                end else begin
                    w_count_nxt = r_count + ONE;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE_LOW;
                w_count_nxt = '0;
                w_out_nxt   = 1'b0;
            end
        endcase
    end

    assign out = r_out;

endmodule

// File: tb/tb_debounce.sv
// Bench for debounce: run-length reference model checked every cycle, plus
// directed latency/glitch/reset scenarios and a randomized soak.
module tb_debounce;

    localparam int CYCLES = 800;
    localparam int SYNC   = 2;
    localparam int LAT    = SYNC + CYCLES;

    logic aclk  = 1'b0;
    logic reset = 1'b1;
    logic in    = 1'b0;
    logic out;

    int vectors     = 0;
    int miscompares = 0;
    bit started     = 1'b0;

    debounce #(
        .CYCLES      (CYCLES),
        .SYNC_STAGES (SYNC)
    ) dut (
        .aclk  (aclk),
        .reset (reset),
        .in    (in),
        .out   (out)
    );

    always #1 aclk = ~aclk;

    // Reference: the filter sees in delayed by SYNC samples; out flips once
    // CYCLES consecutive samples have disagreed with it.
    bit m_hist [SYNC];
    int m_run = 0;
    bit m_out = 1'b0;

    always @(posedge aclk) begin : model
        bit s;
        int run;
        bit o;
        if (reset) begin
            for (int i = 0; i < SYNC; i++) m_hist[i] <= 1'b0;
            m_run <= 0;
            m_out <= 1'b0;
        end else begin
            s   = m_hist[SYNC-1];
            run = m_run;
            o   = m_out;
            if (s != o) begin
                run++;
                if (run == CYCLES) begin
                    o   = !o;
                    run = 0;
                end
            end else begin
                run = 0;
            end
            m_hist[0] <= in;
            for (int i = 1; i < SYNC; i++) m_hist[i] <= m_hist[i-1];
            m_run <= run;
            m_out <= o;
        end
    end

    always @(negedge aclk) begin
        if (started) begin
            vectors++;
            if (out !== m_out) begin
                miscompares++;
                $display("FAIL out_vs_model t=%0t: dut=%b model=%b", $time, out, m_out);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive v from a negedge and count edges until out==want (bounded).
    task automatic hold_until(input bit v, input bit want, input int max, output int n);
        in = v;
        n  = 0;
        while (n < max) begin
            @(posedge aclk);
            n++;
            @(negedge aclk);
            if (out === want) break;
        end
    endtask

    initial begin
        int n;
        int len;
        int mode;

        // Reset held with in high: out stays low, then a fresh rising qualification.
        reset = 1'b1;
        in    = 1'b1;
        repeat (8) begin
            @(posedge aclk);
            started = 1'b1;
            @(negedge aclk);
            check("out_during_reset", out, 0);
        end
        reset = 1'b0;
        hold_until(1'b1, 1'b1, 2000, n);
        check("rise_after_reset", n, LAT);

        // Bounce with out high, then settle low.
        for (int i = 0; i < 100; i++) begin
            in = i[0];
            @(negedge aclk);
        end
        check("high_held_bounce", out, 1);
        hold_until(1'b0, 1'b0, 2000, n);
        check("fall_after_bounce", n, LAT);

        // Bounce with out low, then settle high for 1000 cycles.
        for (int i = 0; i < 100; i++) begin
            in = ~i[0];
            @(negedge aclk);
        end
        check("low_held_bounce", out, 0);
        hold_until(1'b1, 1'b1, 1000, n);
        check("rise_after_bounce", n, LAT);
        repeat (1000 - n) @(negedge aclk);

        // Continuous toggling never moves out.
        for (int i = 0; i < 4000; i++) begin
            in = i[0];
            @(negedge aclk);
        end
        check("toggle_4000_hold", out, 1);

        // One-short-of-qualification high, single low glitch, then high.
        reset = 1'b1;
        in    = 1'b0;
        repeat (2) @(negedge aclk);
        check("out_after_reset", out, 0);
        reset = 1'b0;
        repeat (4) @(negedge aclk);
        in = 1'b1;
        repeat (CYCLES - 1) @(negedge aclk);
        in = 1'b0;
        @(negedge aclk);
        check("glitch_799", out, 0);
        hold_until(1'b1, 1'b1, 2000, n);
        check("rise_after_glitch", n, LAT);

        // Reset mid-qualification.
        reset = 1'b1;
        in    = 1'b0;
        repeat (2) @(negedge aclk);
        reset = 1'b0;
        repeat (4) @(negedge aclk);
        in = 1'b1;
        repeat (SYNC + 400) @(negedge aclk);
        check("count_at_400", dut.r_count, 400);
        check("out_mid_qual", out, 0);
        reset = 1'b1;
        @(negedge aclk);
        check("out_after_abort", out, 0);
        check("count_after_abort", dut.r_count, 0);
        reset = 1'b0;
        hold_until(1'b1, 1'b1, 2000, n);
        check("rise_after_abort", n, LAT);

        // Randomized segments: holds, fast chatter, short resets.
        for (int seg = 0; seg < 40; seg++) begin
            mode = $urandom_range(0, 5);
            if (mode <= 2) begin
                len = (mode == 0) ? $urandom_range(CYCLES - 3, CYCLES + 5)
                                  : $urandom_range(1, 1200);
                in = $urandom_range(0, 1);
                repeat (len) @(negedge aclk);
            end else if (mode <= 4) begin
                len = $urandom_range(1, 300);
                for (int i = 0; i < len; i++) begin
                    in = $urandom_range(0, 1);
                    @(negedge aclk);
                end
            end else begin
                reset = 1'b1;
                in    = $urandom_range(0, 1);
                repeat ($urandom_range(1, 3)) @(negedge aclk);
                reset = 1'b0;
            end
        end
        repeat (LAT + 5) @(negedge aclk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/debounce.md
DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 The block SHALL have parameter CYCLES, default 1000, giving the number of consecutive clock cycles the synchronized input must hold a new level before out follows; legal range 2..65535.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of input synchronizer flops; legal range 2..4.
REQ-003 The block SHALL have port aclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in, input, 1 bit: raw asynchronous bouncy input, e.g. a switch or rotary-encoder contact.
REQ-006 The block SHALL have port out, output, 1 bit: the debounced level, driven directly by a register.

Function
REQ-007 in SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (s) feeds the filter logic.
REQ-008 The filter SHALL be a 4-state FSM: STABLE_LOW (out=0), PENDING_HIGH (out=0), STABLE_HIGH (out=1), PENDING_LOW (out=1).
REQ-009 From STABLE_LOW with s=1, it SHALL go to PENDING_HIGH with count=1; from STABLE_HIGH with s=0, it SHALL go to PENDING_LOW with count=1.
REQ-010 In PENDING_x, if s still differs from out and count<CYCLES-1, count SHALL increment.
REQ-011 In PENDING_x, if s still differs from out and count==CYCLES-1, out SHALL toggle on that edge, the FSM SHALL enter the matching STABLE state, and count SHALL clear to 0.
REQ-012 In PENDING_x, if s equals out, the FSM SHALL return to the previous STABLE state and count SHALL clear to 0 (any glitch restarts the qualification).
REQ-013 Latency: for a clean input step, out SHALL change on rising edge SYNC_STAGES+CYCLES, counting the first edge that samples the new in level as edge 1.
REQ-014 A pulse or stable interval on s shorter than CYCLES cycles SHALL never change out.
REQ-015 Continuous toggling of in at any rate SHALL hold out at its current value indefinitely.
REQ-016 The count register SHALL be $clog2(CYCLES) bits wide, unsigned, and SHALL never wrap.
REQ-017 out SHALL change at most once per CYCLES cycles and SHALL have no combinational path from in.

Reset
REQ-018 While reset=1 at a rising edge, all synchronizer flops SHALL clear to 0, count to 0, FSM to STABLE_LOW and out to 0; reset SHALL take priority over all other conditions.
REQ-019 On the first edge after reset deasserts, normal sampling SHALL resume; a high in present during reset SHALL be qualified as a new rising transition (latency per REQ-013).
REQ-020 Reset asserted mid-qualification SHALL abort the qualification with no out change.

Structure
REQ-021 The FSM state enum (2 bits) and the SYNC_STAGES default SHALL live in shared package debounce_pkg.
REQ-022 The synchronizer SHALL be a separate sub-module sync_chain (parameter STAGES, ports aclk, reset, d, q).
REQ-023 The block SHALL contain no latches, no asynchronous logic and no clock gating.

Verification (CYCLES=800, SYNC_STAGES=2, 2 ns clock)
REQ-024 Bench SHALL cover: reset high for 8 cycles with in=1 -> out=0 throughout reset; out=1 exactly 802 edges after reset deasserts.
REQ-025 Bench SHALL cover: in toggling every cycle for 100 cycles and then held at 1 for 1000 cycles -> out stays 0 during bouncing and rises 802 edges after the final 0->1 sample.
REQ-026 Bench SHALL cover: with out=1, in bouncing for 100 cycles and then held at 0 -> out falls 802 edges after the final 1->0 sample.
REQ-027 Bench SHALL cover: in toggling every cycle for 4000 cycles -> out is never changed.
REQ-028 Bench SHALL cover: in high for 799 cycles, low for 1 cycle, then high -> out rises only 802 edges after the final 0->1 sample.
REQ-029 Bench SHALL cover: reset pulsed at count=400 while out=0 and in=1 -> out stays 0 and count=0 after the reset edge; out rises 802 edges after reset deasserts.
